apb4_wwdg: RTL and testbench
============================

APB4_WWDG -- requirements
Module: apb4_wwdg

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, named pclk and presetn as in the other APB4 peripherals.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 32, range 8..32: timeout counter and CMP/WIN/EWI width.
REQ-003 The block SHALL have parameter PSCR_WIDTH, default 20, range 1..32: prescaler width.
REQ-004 Port pclk, input, width 1: clock.
REQ-005 Port presetn, input, width 1: async active-low reset.
REQ-006 Port paddr, input, width 32: APB4 address; only [5:2] is decoded.
REQ-007 Ports psel, penable, pwrite, each input, width 1: APB4 control.
REQ-008 Port pwdata, input, width 32: write data.
REQ-009 Port prdata, output, width 32: read data; 0 outside a read access phase.
REQ-010 Port pready, output, width 1: tied to 1.
REQ-011 Port pslverr, output, width 1: error response.
REQ-012 Port irq_o, output, width 1: early-warning interrupt, level.
REQ-013 Port rst_o, output, width 1: system reset request, level.

Function
REQ-014 Access phase SHALL be psel&penable; wr = access&pwrite; rd = access&~pwrite.
REQ-015 Map, paddr[5:2]: 0 CTRL, 1 PSCR, 2 CMP, 3 WIN, 4 EWI, 5 STAT, 6 KEY, 7 FEED, 8 CNT (read-only).
REQ-016 pslverr SHALL be 1 during an access to addr > 8, or during a write to CNT.
REQ-017 pslverr SHALL be 1 during a write to CTRL/PSCR/CMP/WIN/EWI while LOCK=1; such writes SHALL be ignored.
REQ-018 KEY write SHALL store pwdata; key_ok = (KEY == 0x5F37_59DF).
REQ-019 Any wr to an address other than KEY SHALL clear KEY the next cycle, making the unlock one-shot.
REQ-020 Writes to CTRL, PSCR, CMP, WIN, EWI and FEED SHALL take effect only when key_ok; otherwise they SHALL be ignored with pslverr=0.
REQ-021 CTRL[4:0] SHALL be {LOCK, WINEN, EWIEN, RSTEN, EN}.
REQ-022 LOCK SHALL be sticky until reset.
REQ-023 Prescaler: when EN, pcnt SHALL increment each pclk; at pcnt==PSCR it SHALL emit a 1-cycle tick and reload 0. PSCR=0 SHALL give a tick every cycle.
REQ-024 While EN=0, pcnt and CNT SHALL hold their values.
REQ-025 On tick, if CNT==CMP: timeout, STAT.TO set, CNT←0; else CNT←CNT+1 (no other wrap).
REQ-026 On tick with EWIEN=1 and the new CNT==EWI, STAT.EW SHALL be set.
REQ-027 A FEED write of pwdata[0]=1 with key_ok SHALL be classed as an early feed when WINEN=1 and CNT<WIN.
REQ-028 An early feed SHALL set STAT.WV and STAT.TO and SHALL clear CNT and pcnt.
REQ-029 A feed that is not early SHALL clear CNT and pcnt next cycle with no flag change.
REQ-030 A feed and a tick in the same cycle: the feed SHALL win (CNT←0, no timeout, no EW).
REQ-031 STAT[2:0] SHALL be {WV, EW, TO}, write-1-to-clear, with no key needed.
REQ-032 A set event and a W1C clear on the same bit in the same cycle: set SHALL win.
REQ-033 irq_o SHALL equal STAT.EW & EWIEN, registered.
REQ-034 rst_o SHALL equal STAT.TO & RSTEN, registered.
REQ-035 prdata SHALL return each register zero-extended to 32 bits; KEY SHALL read 0.

Reset
REQ-036 presetn=0 SHALL async clear CTRL, PSCR, WIN, KEY, STAT, pcnt and CNT.
REQ-037 presetn=0 SHALL async set CMP and EWI to all-ones.
REQ-038 While presetn=0, irq_o=0, rst_o=0 and prdata=0.
REQ-039 Reset asserted mid-count SHALL abort with no pending tick or flag.

Verification
REQ-040 Write CMP=5 with no prior KEY -> CMP stays 0xFFFFFFFF; with KEY then CMP=5 -> reads 5; a second CMP write without a new KEY is ignored.
REQ-041 KEY, PSCR=3; KEY, CMP=5; KEY, CTRL=0x3 -> tick every 4 cycles; after 24 cycles STAT=0x1 and rst_o=1; W1C 0x1 -> rst_o=0.
REQ-042 CMP=100, WIN=50, WINEN=1: feed at CNT=20 -> STAT=0x5 and CNT=0; feed at CNT=60 -> CNT=0 and STAT unchanged.
REQ-043 EWI=10, EWIEN=1, PSCR=0 -> irq_o rises 1 cycle after CNT reaches 10; W1C 0x2 -> irq_o=0.
REQ-044 Set LOCK, then KEY+CTRL=0 -> pslverr=1 and CTRL unchanged; feed aligned with the CNT==CMP tick -> no timeout.
REQ-045 Assert presetn mid-count at CNT=7 -> all registers return to reset values, rst_o=0 and irq_o=0 immediately.

Source files
------------

// File: rtl/apb4_wwdg_if.sv
// apb4_wwdg_if: APB4 completer bus bundle for the windowed watchdog
interface apb4_wwdg_if;
  logic [31:0] paddr, pwdata, prdata;
  logic psel, penable, pwrite, pready, pslverr;
  modport master (output paddr, psel, penable, pwrite, pwdata, input prdata, pready, pslverr);
  modport slave (input paddr, psel, penable, pwrite, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/apb4_wwdg.sv
// apb4_wwdg: APB4 windowed watchdog with key-protected config, early-warning irq and reset request
module apb4_wwdg #(
  parameter int CNT_WIDTH  = 32,
  parameter int PSCR_WIDTH = 20
) (
  input  logic       pclk,
  input  logic       presetn,
  apb4_wwdg_if.slave bus,
  output logic       irq_o,
  output logic       rst_o
);
  localparam logic [31:0] KEY_VAL = 32'h5F37_59DF;
  localparam logic [3:0] A_CTRL = 4'd0, A_PSCR = 4'd1, A_CMP = 4'd2, A_WIN = 4'd3, A_EWI = 4'd4;
  localparam logic [3:0] A_STAT = 4'd5, A_KEY = 4'd6, A_FEED = 4'd7, A_CNT = 4'd8;
  logic [4:0] ctrl;
  logic [PSCR_WIDTH-1:0] pscr, pcnt;
  logic [CNT_WIDTH-1:0] cmp, win, ewi, cnt, cnt_inc;
  logic [31:0] key;
  logic [2:0] stat, w1c, stat_set;
  logic [3:0] addr;
  logic acc, wr, rd, lock, key_ok, cfg_wr, feed, early, tick, wrap, timeout, ew_set, unused_ok;
  assign addr      = bus.paddr[5:2];
  assign acc       = bus.psel & bus.penable;
  assign wr        = acc & bus.pwrite;
  assign rd        = acc & ~bus.pwrite;
  assign lock      = ctrl[4];
  assign key_ok    = key == KEY_VAL;
  assign cfg_wr    = wr & key_ok & ~lock & (addr <= A_EWI);
  assign feed      = wr & key_ok & (addr == A_FEED) & bus.pwdata[0];
  assign early     = feed & ctrl[3] & (cnt < win);
  assign tick      = ctrl[0] & (pcnt == pscr);
  assign wrap      = cnt == cmp;
  assign cnt_inc   = wrap ? '0 : cnt + CNT_WIDTH'(1);
  assign timeout   = tick & ~feed & wrap;
  assign ew_set    = tick & ~feed & ctrl[2] & (cnt_inc == ewi);
  assign w1c       = (wr & (addr == A_STAT)) ? bus.pwdata[2:0] : 3'b0;
  assign stat_set  = {early, ew_set, timeout | early};
  assign bus.pready  = 1'b1;
  assign bus.pslverr = acc & ((addr > A_CNT) | (wr & (addr == A_CNT)) | (wr & lock & (addr <= A_EWI)));
  assign unused_ok = &{1'b0, bus.paddr[31:6], bus.paddr[1:0], bus.pwdata};
  // key latch: armed by a KEY write, dropped by any other write so unlock is one-shot
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) key <= '0;
    else if (wr) key <= (addr == A_KEY) ? bus.pwdata : '0;
  // configuration registers; LOCK stays set once written
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      ctrl <= '0;
      pscr <= '0;
      cmp  <= '1;
      win  <= '0;
      ewi  <= '1;
    end else if (cfg_wr) begin
      if (addr == A_CTRL) ctrl <= {lock | bus.pwdata[4], bus.pwdata[3:0]};
      if (addr == A_PSCR) pscr <= bus.pwdata[PSCR_WIDTH-1:0];
      if (addr == A_CMP) cmp <= bus.pwdata[CNT_WIDTH-1:0];
      if (addr == A_WIN) win <= bus.pwdata[CNT_WIDTH-1:0];
      if (addr == A_EWI) ewi <= bus.pwdata[CNT_WIDTH-1:0];
    end
  // prescaler and timeout counter; a feed overrides a tick in the same cycle
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      pcnt <= '0;
      cnt  <= '0;
    end else if (feed) begin
      pcnt <= '0;
      cnt  <= '0;
    end else if (ctrl[0]) begin
      pcnt <= tick ? '0 : pcnt + PSCR_WIDTH'(1);
      if (tick) cnt <= cnt_inc;
    end
  // W1C status where a set event beats a clear, plus registered irq/reset requests
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      stat  <= '0;
      irq_o <= 1'b0;
      rst_o <= 1'b0;
    end else begin
      stat  <= (stat & ~w1c) | stat_set;
      irq_o <= stat[1] & ctrl[2];
      rst_o <= stat[0] & ctrl[1];
    end
  // read mux, zero outside a read access and while reset is held
  always_comb begin
    bus.prdata = '0;
    if (rd & presetn)
      case (addr)
        A_CTRL:  bus.prdata = 32'(ctrl);
        A_PSCR:  bus.prdata = 32'(pscr);
        A_CMP:   bus.prdata = 32'(cmp);
        A_WIN:   bus.prdata = 32'(win);
        A_EWI:   bus.prdata = 32'(ewi);
        A_STAT:  bus.prdata = 32'(stat);
        A_CNT:   bus.prdata = 32'(cnt);
        default: bus.prdata = '0;
      endcase
  end
endmodule

// File: tb/tb_apb4_wwdg.sv
// tb_apb4_wwdg: vector table, directed corner sequences and random traffic against a register-map model
module tb_apb4_wwdg;
  localparam logic [31:0] KEY = 32'h5F37_59DF;
  typedef struct {
    logic        w;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] rdata;
    logic        err;
  } vec_t;
  logic pclk = 1'b0;
  logic presetn = 1'b0;
  logic irq_o, rst_o;
  logic s_irq, s_rst;
  logic [31:0] rv;
  logic ev;
  int n_chk = 0, n_pass = 0;
  logic [31:0] m_reg [0:15];
  logic [31:0] m_key, m_pcnt;
  logic m_irq, m_rst;
  apb4_wwdg_if bus ();
  apb4_wwdg dut (.pclk(pclk), .presetn(presetn), .bus(bus), .irq_o(irq_o), .rst_o(rst_o));
  always #5 pclk = ~pclk;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic m_reset();
    foreach (m_reg[i]) m_reg[i] = '0;
    m_reg[2] = '1;
    m_reg[4] = '1;
    m_key = '0;
    m_pcnt = '0;
    m_irq = 1'b0;
    m_rst = 1'b0;
  endtask

  function automatic logic [32:0] m_resp(logic acc, logic w, logic [3:0] a);
    logic [31:0] r = '0;
    if (acc && !w && presetn && a <= 8 && a != 6) r = m_reg[a];
    return {acc && (a > 8 || (w && a == 8) || (w && m_reg[0][4] && a <= 4)), r};
  endfunction

  task automatic m_step(logic acc, logic w, logic [3:0] a, logic [31:0] d);
    logic [31:0] n [0:15];
    logic kok, tick, feed, early, to, ew;
    logic [31:0] w1c;
    if (!presetn) begin
      m_reset();
      return;
    end
    n = m_reg;
    kok = m_key == KEY;
    tick = m_reg[0][0] && m_pcnt == m_reg[1];
    feed = w && a == 7 && kok && d[0];
    early = feed && m_reg[0][3] && m_reg[8] < m_reg[3];
    to = early;
    ew = 1'b0;
    if (w && kok && !m_reg[0][4] && a <= 4)
      n[a] = a == 0 ? {27'b0, m_reg[0][4] | d[4], d[3:0]} : a == 1 ? d & 32'h000F_FFFF : d;
    if (feed) begin
      n[8] = 0;
      m_pcnt = 0;
    end else if (m_reg[0][0]) begin
      m_pcnt = tick ? 0 : m_pcnt + 1;
      if (tick) begin
        if (m_reg[8] == m_reg[2]) begin
          to = 1'b1;
          n[8] = 0;
        end else n[8] = m_reg[8] + 1;
        ew = m_reg[0][2] && n[8] == m_reg[4];
      end
    end
    w1c = (w && a == 5) ? d : 0;
    n[5] = ((m_reg[5] & ~w1c) | {29'b0, early, ew, to}) & 32'h7;
    m_irq = m_reg[5][1] & m_reg[0][2];
    m_rst = m_reg[5][0] & m_reg[0][1];
    if (w) m_key = a == 6 ? d : 0;
    m_reg = n;
  endtask

  task automatic cycle(logic sel, logic en, logic wr, logic [3:0] a, logic [31:0] d,
                       output logic [31:0] rdata, output logic err);
    logic [32:0] e;
    @(negedge pclk);
    bus.psel = sel;
    bus.penable = en;
    bus.pwrite = wr;
    bus.paddr = ($urandom() & 32'hFFFF_FFC3) | {26'b0, a, 2'b0};
    bus.pwdata = d;
    #1;
    e = m_resp(sel & en, sel & en & wr, a);
    rdata = bus.prdata;
    err = bus.pslverr;
    s_irq = irq_o;
    s_rst = rst_o;
    check("bus {pslverr,irq,rst,prdata}", {29'b0, bus.pslverr, irq_o, rst_o, bus.prdata},
          {29'b0, e[32], m_irq, m_rst, e[31:0]});
    @(posedge pclk);
    m_step(sel & en, sel & en & wr, a, d);
  endtask

  task automatic apb(logic wr, logic [3:0] a, logic [31:0] d, output logic [31:0] rdata, output logic err);
    logic [31:0] r0;
    logic e0;
    cycle(1'b1, 1'b0, wr, a, d, r0, e0);
    cycle(1'b1, 1'b1, wr, a, d, rdata, err);
  endtask

  task automatic idle(int n);
    logic [31:0] r;
    logic e;
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, r, e);
  endtask

  task automatic kwr(logic [3:0] a, logic [31:0] d);
    logic [31:0] r;
    logic e;
    apb(1'b1, 4'd6, KEY, r, e);
    apb(1'b1, a, d, r, e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    logic [31:0] rst_val [0:8];
    int k;
    bus.psel = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite = 1'b0;
    bus.paddr = '0;
    bus.pwdata = '0;
    m_reset();
    rst_val = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl.push_back('{1'b0, 4'd0, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 4'd1, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 4'd2, 32'h0, 32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{1'b0, 4'd3, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 4'd4, 32'h0, 32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{1'b0, 4'd5, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 4'd8, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{1'b1, 4'd2, 32'h5, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 4'd2, 32'h0, 32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{1'b1, 4'd6, KEY, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 4'd6, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{1'b1, 4'd2, 32'h5, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 4'd2, 32'h0, 32'h5, 1'b0});
    tbl.push_back('{1'b1, 4'd2, 32'h7, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 4'd2, 32'h0, 32'h5, 1'b0});
    tbl.push_back('{1'b1, 4'd8, 32'h1, 32'h0, 1'b1});
    tbl.push_back('{1'b0, 4'd9, 32'h0, 32'h0, 1'b1});
    tbl.push_back('{1'b1, 4'd15, 32'h3, 32'h0, 1'b1});
    tbl.push_back('{1'b1, 4'd6, KEY, 32'h0, 1'b0});
    tbl.push_back('{1'b1, 4'd1, 32'h3, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 4'd1, 32'h0, 32'h3, 1'b0});
    tbl.push_back('{1'b1, 4'd5, 32'h7, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 4'd5, 32'h0, 32'h0, 1'b0});
    idle(2);
    #2 presetn = 1'b1;
    foreach (tbl[i]) begin
      apb(tbl[i].w, tbl[i].a, tbl[i].d, rv, ev);
      check($sformatf("vec%0d rdata", i), rv, tbl[i].rdata);
      check($sformatf("vec%0d pslverr", i), ev, tbl[i].err);
    end
    // timeout: PSCR=3, CMP=5, EN|RSTEN
    kwr(4'd0, 32'h3);
    for (k = 0; k < 60; k++) begin
      idle(1);
      if (s_rst) break;
    end
    check("rst_o latency", k, 25);
    apb(1'b0, 4'd5, 0, rv, ev);
    check("stat after timeout", rv, 32'h1);
    apb(1'b1, 4'd5, 32'h1, rv, ev);
    idle(2);
    check("rst_o after w1c", s_rst, 1'b0);
    kwr(4'd0, 32'h0);
    // window: early and late feeds
    kwr(4'd1, 32'h0);
    kwr(4'd2, 32'd100);
    kwr(4'd3, 32'd50);
    kwr(4'd0, 32'h9);
    idle(15);
    kwr(4'd7, 32'h1);
    apb(1'b0, 4'd5, 0, rv, ev);
    check("stat early feed", rv, 32'h5);
    apb(1'b0, 4'd8, 0, rv, ev);
    check("cnt after early feed", rv, 32'd3);
    apb(1'b1, 4'd5, 32'h5, rv, ev);
    idle(55);
    kwr(4'd7, 32'h1);
    apb(1'b0, 4'd5, 0, rv, ev);
    check("stat late feed", rv, 32'h0);
    apb(1'b0, 4'd8, 0, rv, ev);
    check("cnt after late feed", rv, 32'd3);
    // early warning
    kwr(4'd0, 32'h0);
    kwr(4'd4, 32'd10);
    kwr(4'd7, 32'h1);
    kwr(4'd0, 32'h5);
    for (k = 0; k < 40; k++) begin
      idle(1);
      if (s_irq) break;
    end
    check("irq_o latency", k, 11);
    apb(1'b0, 4'd5, 0, rv, ev);
    check("stat early warning", rv, 32'h2);
    apb(1'b1, 4'd5, 32'h2, rv, ev);
    idle(2);
    check("irq_o after w1c", s_irq, 1'b0);
    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      int op;
      logic [3:0] a;
      logic [31:0] d;
      op = $urandom_range(0, 9);
      a = 4'($urandom_range(0, 15));
      d = $urandom();
      if (a == 0) d = d & 32'hF;
      else if (a == 1) d = d & 32'h3;
      else if (a <= 4) d = d & 32'h3F;
      if (op <= 3) kwr(a, d);
      else if (op <= 5) apb(1'b0, a, 0, rv, ev);
      else if (op == 6) apb(1'b1, a, d, rv, ev);
      else if (op == 7) idle($urandom_range(1, 8));
      else if (op == 8) apb(1'b1, 4'd5, d, rv, ev);
      else cycle(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), a, d, rv, ev);
    end
    // lock and feed aligned with the CNT==CMP tick
    kwr(4'd0, 32'h0);
    kwr(4'd1, 32'h0);
    kwr(4'd2, 32'd100);
    kwr(4'd7, 32'h1);
    kwr(4'd0, 32'h13);
    apb(1'b1, 4'd6, KEY, rv, ev);
    apb(1'b1, 4'd0, 32'h0, rv, ev);
    check("locked ctrl write pslverr", ev, 1'b1);
    apb(1'b0, 4'd0, 0, rv, ev);
    check("ctrl after locked write", rv, 32'h13);
    apb(1'b1, 4'd5, 32'h7, rv, ev);
    for (k = 0; k < 300 && m_reg[8] != 97; k++) idle(1);
    check("align wait", k < 300, 1'b1);
    kwr(4'd7, 32'h1);
    apb(1'b0, 4'd5, 0, rv, ev);
    check("stat feed vs tick", rv, 32'h0);
    // reset mid-count
    for (k = 0; k < 200; k++) begin
      idle(1);
      if (s_rst) break;
    end
    check("rst_o before reset", s_rst, 1'b1);
    for (k = 0; k < 50 && m_reg[8] != 7; k++) idle(1);
    check("cnt=7 wait", k < 50, 1'b1);
    #2 presetn = 1'b0;
    #1;
    check("rst_o in reset", rst_o, 1'b0);
    check("irq_o in reset", irq_o, 1'b0);
    bus.psel = 1'b1;
    bus.penable = 1'b1;
    bus.pwrite = 1'b0;
    bus.paddr = 32'h8;
    #1;
    check("prdata in reset", bus.prdata, 32'h0);
    m_reset();
    idle(2);
    #2 presetn = 1'b1;
    for (int a = 0; a <= 8; a++) begin
      apb(1'b0, 4'(a), 0, rv, ev);
      check($sformatf("reset value addr %0d", a), rv, rst_val[a]);
    end
    idle(10);
    apb(1'b0, 4'd5, 0, rv, ev);
    check("stat after reset release", rv, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
